// File: rtl/jk_input_conditioner_pkg.sv
// Shared constants for the JK bench front end: default timing and the level channel bit ordering.
package jk_input_conditioner_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
   localparam int unsigned TICK_DIV_DEFAULT        = 25000000;
   localparam int unsigned NUM_LEVEL_CH            = 4;

   // Bit positions inside raw/clean/rise/fall, shared with the JK stage.
   typedef enum int unsigned {
      CH_J  = 0,
      CH_K  = 1,
      CH_SD = 2,
      CH_RD = 3
   } jk_ch_e;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/jk_input_conditioner_if.sv
// Board-side inputs and conditioned outputs of the JK front end.
interface jk_input_conditioner_if #(
   parameter int unsigned WIDTH = 4
);
   logic [WIDTH-1:0] raw;
   logic             step_btn;
   logic             auto_mode;
   logic [WIDTH-1:0] clean;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic             tick;

   modport master (
      output raw, step_btn, auto_mode,
      input  clean, rise, fall, tick
   );

   modport slave (
      input  raw, step_btn, auto_mode,
      output clean, rise, fall, tick
   );
endinterface

// File: rtl/jk_input_conditioner_debounce_channel.sv
// One asynchronous bit: 2-flop synchronizer, stability counter, debounced level and edge pulses.
module debounce_channel
   import jk_input_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic clean_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          clean_q, clean_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Any return to agreement drops the count: no partial credit for interrupted mismatches.
   always_comb begin
      cnt_d   = '0;
      clean_d = clean_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync2_q != clean_q) begin
         if (cnt_q == CNT_LAST) begin
            clean_d = sync2_q;
            rise_d  = sync2_q;
            fall_d  = ~sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         clean_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= async_i;
         sync2_q <= sync1_q;
         clean_q <= clean_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign clean_o = clean_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/jk_input_conditioner.sv
// Debounced J/K/SD/RD levels plus a single-cycle tick enable from a divider or a step button.
module jk_input_conditioner
   import jk_input_conditioner_pkg::*;
#(
   parameter int unsigned WIDTH           = NUM_LEVEL_CH,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned TICK_DIV        = TICK_DIV_DEFAULT
) (
   input logic                   clk,
   input logic                   rst,
   jk_input_conditioner_if.slave bus
);

   localparam int unsigned   DW       = cnt_width(TICK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

   logic [WIDTH:0] ch_in;
   logic [WIDTH:0] ch_clean;
   logic [WIDTH:0] ch_rise;
   logic [WIDTH:0] ch_fall;
   logic           step_rise;
   logic           step_unused;

   logic           auto_s1_q, auto_s2_q, auto_prev_q;
   logic [DW-1:0]  div_q, div_d;
   logic           mode_chg;
   logic           tick_w;

   // The top channel is the step button; the rest map one-to-one onto raw.
   assign ch_in = {bus.step_btn, bus.raw};

   for (genvar g = 0; g <= WIDTH; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .async_i (ch_in[g]),
         .clean_o (ch_clean[g]),
         .rise_o  (ch_rise[g]),
         .fall_o  (ch_fall[g])
      );
   end

   assign step_rise   = ch_rise[WIDTH];
   assign step_unused = ch_clean[WIDTH] ^ ch_fall[WIDTH];

   // A mode change restarts the divider and swallows whatever tick source fired this cycle.
   always_comb begin
      mode_chg = auto_s2_q ^ auto_prev_q;
      div_d    = '0;
      tick_w   = 1'b0;
      if (!mode_chg) begin
         if (auto_s2_q) begin
            tick_w = (div_q == DIV_LAST);
            div_d  = tick_w ? '0 : div_q + 1'b1;
         end else begin
            tick_w = step_rise;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         auto_s1_q   <= 1'b0;
         auto_s2_q   <= 1'b0;
         auto_prev_q <= 1'b0;
         div_q       <= '0;
      end else begin
         auto_s1_q   <= bus.auto_mode;
         auto_s2_q   <= auto_s1_q;
         auto_prev_q <= auto_s2_q;
         div_q       <= div_d;
      end
   end

   assign bus.clean = ch_clean[WIDTH-1:0];
   assign bus.rise  = ch_rise[WIDTH-1:0];
   assign bus.fall  = ch_fall[WIDTH-1:0];
   assign bus.tick  = tick_w;

endmodule
